// File: rtl/mdu_iter.sv
// Iterative radix-2 RV32M multiply/divide unit.
// One multiplier/quotient bit per cycle; signed operations run on magnitudes
// with sign correction applied in the final FIX cycle before write-back.
module mdu_iter #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic [RFIDX_WIDTH-1:0] rd_in,
  input  logic                   flush,
  output logic                   busy,
  output logic                   done,
  output logic                   reg_write,
  output logic [RFIDX_WIDTH-1:0] rd_out,
  output logic [XLEN-1:0]        result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                   state, state_nxt;
  logic [2:0]               op_r;
  logic [RFIDX_WIDTH-1:0]   rd_r;
  logic [XLEN-1:0]          opnd;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]        acc;       // {partial product | remainder, multiplier | quotient}
  logic                     neg_res;   // product / quotient sign
  logic                     neg_rem;   // remainder follows dividend sign
  logic [CW-1:0]            cnt;

  // Two's-complement negate when n is set.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Operand decode at issue time
  logic            is_div, a_signed, b_signed, sa, sb, div0, ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  // Operand sign handling and special-case detection on the raw request
  always_comb begin
    is_div   = op[2];
    a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_signed = op[2] ? ~op[0] : ~op[1];
    sa       = a_signed & rs1_data[XLEN-1];
    sb       = b_signed & rs2_data[XLEN-1];
    abs_a    = cond_neg(rs1_data, sa);
    abs_b    = cond_neg(rs2_data, sb);
    div0     = is_div && (rs2_data == '0);
    ovf      = is_div && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
               (rs2_data == '1);
  end

  // Iteration step and final output selection
  logic [XLEN:0]        sum, trial, diff;
  logic [2*XLEN-1:0]    mul_step, div_step, prod;
  logic [XLEN-1:0]      quo, rem, fix_val;

  // One radix-2 step for multiply (shift-add) and divide (restoring)
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_step = {sum, acc[XLEN-1:1]};
    trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = trial - {1'b0, opnd};
    div_step = diff[XLEN] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    prod     = cond_neg2(acc, neg_res);
    quo      = cond_neg(acc[XLEN-1:0], neg_res);
    rem      = cond_neg(acc[2*XLEN-1:XLEN], neg_rem);
    case (op_r)
      3'b000:                 fix_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = quo;
      default:                fix_val = rem;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (div0 || ovf) ? FIX : CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(XLEN-1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      done      = 1'b0;
    end
  end

  assign reg_write = done && (rd_out != '0);

  // Operand capture, iteration and write-back registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= '0;
      rd_r    <= '0;
      opnd    <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          op_r <= op;
          rd_r <= rd_in;
          cnt  <= '0;
          if (div0) begin
            // Quotient all ones, remainder is the raw dividend
            opnd    <= '0;
            acc     <= {rs1_data, {XLEN{1'b1}}};
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
          end else if (ovf) begin
            // Most-negative / -1: quotient wraps to itself, remainder zero
            opnd    <= '0;
            acc     <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
          end else begin
            opnd    <= is_div ? abs_b : abs_a;
            acc     <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
            neg_res <= sa ^ sb;
            neg_rem <= sa;
          end
        end
        CALC: begin
          acc <= op_r[2] ? div_step : mul_step;
          cnt <= cnt + 1'b1;
        end
        FIX: if (!flush) begin
          result <= fix_val;
          rd_out <= rd_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit that sits directly downstream of the register-file read ports.
- Consumes rs1/rs2 operand data and produces a write-back triple (reg_write, rd_out, result) for the register-file write port.
- Radix-2: one bit per cycle.
- The core stalls on busy and retires the instruction on done.

Parameters:
- XLEN, 32, operand/result width
- RFIDX_WIDTH, 5, register index width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  input  XLEN  operand A (multiplicand/dividend)
- rs2_data  input  XLEN  operand B (multiplier/divisor)
- rd_in  input  RFIDX_WIDTH  destination register
- flush  input  1  abort current operation
- busy  output  1  operation in progress
- done  output  1  one-cycle result-valid pulse
- reg_write  output  1  write enable to register file; equals done && (rd_out != 0)
- rd_out  output  RFIDX_WIDTH  destination of completed op
- result  output  XLEN  completed result

Behaviour:
- Reset values (rst=1 at a rising edge): state IDLE; busy=0, done=0, reg_write=0, rd_out=0, result=0; counter and internal registers 0.
- rst has priority over flush and start.
- States:
  - IDLE: start=1 latches op, rd_in and operands. Signed ops (MUL*, DIV, REM) take absolute values and record the result sign. Next state is CALC, or FIX if a special case applies.
  - CALC: XLEN iterations, counter 0..XLEN-1.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - After the last iteration, go to FIX.
  - FIX:
    - Apply sign correction: product negated if the signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
    - Select the output: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
    - Register result and rd_out, then go to DONE.
  - DONE: done=1 for exactly this cycle, then IDLE.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
- busy=1 in CALC and FIX. busy=0 in IDLE and DONE; start is accepted only in IDLE.
- Latency, normal case: start sampled at edge 0 → CALC on edges 1..XLEN → FIX result at edge XLEN+1 → done high in the cycle after edge XLEN+1. For XLEN=32, done rises 34 cycles after the start edge.
- Special cases skip CALC (IDLE→FIX→DONE); done is high in the cycle following edge 1.
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
  - Multiplies have no special case.
- start while busy=1 or in DONE: ignored; no latch, no queueing.
- flush=1: next state IDLE from any state; done suppressed; result and rd_out keep their previous values. flush in the same cycle as start in IDLE: flush wins and start is dropped.
- rd_in=0: the operation runs normally and done pulses, but reg_write stays 0.
- result and rd_out hold their value after done until the next completed operation.
- Operands are captured at start; changes on rs1_data/rs2_data afterwards have no effect.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3), rd=5 → busy high 33 cycles; done+reg_write pulse 34 cycles after start; result=0xFFFFFFEB; rd_out=5.
- MULH 0x80000000 × 0x80000000 → result=0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → result=0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → result=0xFFFFFFFD. REM same operands → result=0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → result=0xFFFFFFFF, done 2 cycles after start. REMU 5/0 → result=5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same → 0. Both also 2-cycle latency.
- Abort and protocol checks:
  - start MUL, then flush at cycle 10 → busy=0 next cycle; no done; result unchanged.
  - start MUL, then rst at cycle 10 → all outputs 0.
  - start pulsed at cycle 5 of a busy op → ignored; single done.
- MUL 3×4 with rd_in=0 → done=1, result=12, reg_write=0.
- Back-to-back: start asserted in the cycle after done → accepted; second result correct.
